// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and constants for the two-sensor ultrasonic ranging scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sonar_pkg;

   localparam int DIST_W    = 9;
   localparam int US_PER_CM = 58;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      GAP
   } state_e;

endpackage

// File: rtl/sonar_tick_gen.sv
// sonar_tick_gen: one-cycle microsecond tick derived from CLK_HZ, with phase restart.
// Latency: first tick DIV cycles after clr_i deasserts, then every DIV cycles.
// Backpressure: none; clr_i restarts the phase so interval timing starts cleanly.
module sonar_tick_gen #(
   parameter int CLK_HZ = 65_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(DIV - 1));

   // Divider: wrap on tick, restart on clear.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || tick_o) cnt_d = '0;
   end

   // Divider register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: alternates two ultrasonic sensors (trigger, echo timing, floor(us/58) cm).
// Latency: result and one-cycle dist_valid on the edge after echo fall, saturation or rise timeout.
// Backpressure: none; results are strobes. SONAR_FILTER_EN enables a 2-tap averaging filter.
module sonar_scheduler
   import sonar_pkg::*;
#(
   parameter int CLK_HZ          = 65_000_000,
   parameter int TRIG_US         = 10,
   parameter int RISE_TIMEOUT_US = 1000,
   parameter int GAP_US          = 60000,
   parameter int MAX_CM          = 400
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              echo,
   input  logic              echo_second,
   output logic              trig,
   output logic              trig_second,
   output logic [DIST_W-1:0] dist_0,
   output logic [DIST_W-1:0] dist_1,
   output logic [1:0]        dist_valid,
   output logic [1:0]        timeout
);

   localparam int TMAX0 = (TRIG_US > RISE_TIMEOUT_US) ? TRIG_US : RISE_TIMEOUT_US;
   localparam int TMAX  = (TMAX0 > GAP_US) ? TMAX0 : GAP_US;
   localparam int TW    = $clog2(TMAX + 1);
   localparam int US_W  = $clog2(US_PER_CM);

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [US_W-1:0]   us_q, us_d;
   logic [DIST_W-1:0] cm_q, cm_d, cm_nxt;
   logic [DIST_W-1:0] dist0_q, dist0_d, dist1_q, dist1_d;
   logic [1:0]        valid_q, valid_d, tout_q, tout_d;
   logic              trig_q, trig_d, trig2_q, trig2_d;
   logic [1:0]        sync1_q, sync2_q, prev_q;
   logic              tick, tick_clr, cm_inc, rise, fall;
   logic              res_upd, res_to;
   logic [DIST_W-1:0] res_raw, res_dist;

   sonar_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   // Restart the us phase whenever an interval starts so widths are cycle-exact.
   assign tick_clr = (state_q == IDLE) || (state_d != state_q);

   // Only the selected sensor's synchronized edges are ever looked at.
   assign rise = sync2_q[sel_q] & ~prev_q[sel_q];
   assign fall = ~sync2_q[sel_q] & prev_q[sel_q];

   // Two-flop synchronizers plus one history flop for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= {echo_second, echo};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Measurement FSM: interval counting, cm accumulation and result request.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tcnt_d  = tcnt_q;
      us_d    = us_q;
      cm_d    = cm_q;
      res_upd = 1'b0;
      res_to  = 1'b0;
      res_raw = '0;
      cm_inc  = tick && (us_q == US_W'(US_PER_CM - 1));
      cm_nxt  = cm_q + DIST_W'(cm_inc);
      case (state_q)
         IDLE: if (enable) begin
            state_d = TRIG;
            tcnt_d  = '0;
         end
         TRIG: if (tick) begin
            if (tcnt_q == TW'(TRIG_US - 1)) begin
               state_d = WAIT_RISE;
               tcnt_d  = '0;
            end else tcnt_d = tcnt_q + TW'(1);
         end
         WAIT_RISE: if (rise) begin
            state_d = MEASURE;
            us_d    = '0;
            cm_d    = '0;
         end else if (tick) begin
            if (tcnt_q == TW'(RISE_TIMEOUT_US - 1)) begin
               state_d = GAP;
               tcnt_d  = '0;
               res_upd = 1'b1;
               res_to  = 1'b1;
            end else tcnt_d = tcnt_q + TW'(1);
         end
         MEASURE: begin
            // A tick landing on the fall cycle still counts toward the result.
            if (cm_nxt >= DIST_W'(MAX_CM)) begin
               state_d = GAP;
               tcnt_d  = '0;
               res_upd = 1'b1;
               res_to  = 1'b1;
            end else if (fall) begin
               state_d = GAP;
               tcnt_d  = '0;
               res_upd = 1'b1;
               res_raw = cm_nxt;
            end else begin
               cm_d = cm_nxt;
               if (tick) us_d = cm_inc ? '0 : us_q + US_W'(1);
            end
         end
         GAP: if (tick) begin
            if (tcnt_q == TW'(GAP_US - 1)) begin
               state_d = IDLE;
               sel_d   = ~sel_q;
               tcnt_d  = '0;
            end else tcnt_d = tcnt_q + TW'(1);
         end
         default: state_d = IDLE;
      endcase
      trig_d  = (state_d == TRIG) && !sel_q;
      trig2_d = (state_d == TRIG) && sel_q;
   end

`ifdef SONAR_FILTER_EN
   logic [1:0]        seen_q;
   logic [DIST_W-1:0] prev_dist;
   logic [DIST_W:0]   sum;

   // Average with the previously reported value; first result and timeouts pass through.
   always_comb begin
      prev_dist = sel_q ? dist1_q : dist0_q;
      sum       = {1'b0, prev_dist} + {1'b0, res_raw};
      if (res_to)             res_dist = DIST_W'(MAX_CM);
      else if (seen_q[sel_q]) res_dist = sum[DIST_W:1];
      else                    res_dist = res_raw;
   end

   // Remember which sensors have reported since reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         seen_q         <= '0;
      else if (res_upd) seen_q[sel_q] <= 1'b1;
   end
`else
   // Raw reporting; timeouts and saturation report MAX_CM.
   always_comb begin
      res_dist = res_to ? DIST_W'(MAX_CM) : res_raw;
   end
`endif

   // Result registers: only the selected sensor's slot is written.
   always_comb begin
      dist0_d = dist0_q;
      dist1_d = dist1_q;
      tout_d  = tout_q;
      valid_d = '0;
      if (res_upd) begin
         valid_d[sel_q] = 1'b1;
         tout_d[sel_q]  = res_to;
         if (sel_q) dist1_d = res_dist;
         else       dist0_d = res_dist;
      end
   end

   // State and output registers; reset discards any partial measurement.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         tcnt_q  <= '0;
         us_q    <= '0;
         cm_q    <= '0;
         dist0_q <= '0;
         dist1_q <= '0;
         valid_q <= '0;
         tout_q  <= '0;
         trig_q  <= 1'b0;
         trig2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tcnt_q  <= tcnt_d;
         us_q    <= us_d;
         cm_q    <= cm_d;
         dist0_q <= dist0_d;
         dist1_q <= dist1_d;
         valid_q <= valid_d;
         tout_q  <= tout_d;
         trig_q  <= trig_d;
         trig2_q <= trig2_d;
      end
   end

   assign trig        = trig_q;
   assign trig_second = trig2_q;
   assign dist_0      = dist0_q;
   assign dist_1      = dist1_q;
   assign dist_valid  = valid_q;
   assign timeout     = tout_q;

endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 65_000_000, clock frequency in Hz.
REQ-002 Parameter TRIG_US, default 10, trigger pulse width in microseconds.
REQ-003 Parameter RISE_TIMEOUT_US, default 1000, maximum wait from trigger end to echo rise.
REQ-004 Parameter GAP_US, default 60000, quiet time after each measurement before the other sensor is triggered.
REQ-005 Parameter MAX_CM, default 400, distance saturation value.
REQ-006 clk  input  1  system clock; one clock domain only.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  run measurement cycles while high.
REQ-009 echo  input  1  sensor 0 echo, asynchronous.
REQ-010 echo_second  input  1  sensor 1 echo, asynchronous.
REQ-011 trig  output  1  sensor 0 trigger.
REQ-012 trig_second  output  1  sensor 1 trigger.
REQ-013 dist_0  output  9  last sensor 0 distance in cm.
REQ-014 dist_1  output  9  last sensor 1 distance in cm.
REQ-015 dist_valid  output  2  one-cycle update strobe; bit i is for sensor i.
REQ-016 timeout  output  2  bit i is high when sensor i's last result was a timeout or saturated.

Function
REQ-017 Each echo input SHALL pass through a 2-flop synchronizer before use.
REQ-018 A µs tick SHALL pulse once every CLK_HZ/1_000_000 cycles; all timing SHALL count ticks.
REQ-019 FSM states and transitions:
- IDLE -> TRIG when enable=1; the next sensor is fixed at this transition.
- TRIG -> WAIT_RISE after TRIG_US ticks.
- WAIT_RISE -> MEASURE on synchronized echo rise.
- WAIT_RISE -> GAP after RISE_TIMEOUT_US ticks.
- MEASURE -> GAP on synchronized echo fall, or when the cm count reaches MAX_CM.
- GAP -> IDLE after GAP_US ticks; the sensor index toggles at this transition.
REQ-020 Only the selected sensor's trigger SHALL be high, and only in TRIG; its width SHALL be exactly TRIG_US*CLK_HZ/1e6 cycles.
REQ-021 The first cycle after reset SHALL select sensor 0; sensors then strictly alternate 0,1,0,1.
REQ-022 Distance = floor(echo_high_us/58), accumulated by a 58-tick sub-counter; no divider.
REQ-023 Distance SHALL saturate at MAX_CM; saturation ends MEASURE and sets the timeout bit.
REQ-024 On echo fall, the selected dist register and dist_valid bit SHALL update on the next clock edge; timeout bit cleared.
REQ-025 On a WAIT_RISE timeout, dist SHALL be set to MAX_CM, and the timeout bit and dist_valid bit set, on the transition edge.
REQ-026 The unselected sensor's echo SHALL be ignored in all states.
REQ-027 If echo is already high on entry to WAIT_RISE, the block SHALL wait for a fresh rise (edge-detected, not level).
REQ-028 enable SHALL be sampled only in IDLE; deasserting it mid-cycle lets the current measurement and gap complete.
REQ-029 dist_valid SHALL never have both bits set in the same cycle.

Reset
REQ-030 With rst=0 the block SHALL be in IDLE with sensor 0 selected, and all outputs and counters 0, including trig, trig_second, dist_0, dist_1, dist_valid and timeout.
REQ-031 rst asserted mid-measurement SHALL drop trig/trig_second within the reset assertion itself (asynchronous) and discard the partial count.

Configuration
REQ-032 Macro SONAR_FILTER_EN:
- Defined: each reported distance is (previous reported + new raw) >> 1, computed at 10 bits. The first result after reset is reported raw. A timeout result bypasses the filter and reports MAX_CM.
- Undefined: the raw distance is reported and no filter registers exist.

Structure
REQ-033 The package sonar_pkg SHALL hold:
- the FSM state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GAP);
- the DIST_W=9 constant;
- the US_PER_CM=58 constant.
REQ-034 One sub-module, sonar_tick_gen, SHALL generate the µs tick from CLK_HZ; the synchronizers and FSM SHALL be inline.

Verification (CLK_HZ=65e6, SONAR_FILTER_EN undefined unless stated)
REQ-035 Bench scenarios:
- Enable, sensor 0 echo high 580 µs -> trig high 650 cycles; dist_0=10; dist_valid=2'b01 for one cycle; timeout[0]=0.
- Sensor 0 echo never rises -> after 1000 µs, dist_0=400, timeout[0]=1, dist_valid[0] pulse; GAP then trig_second asserted.
- Echo high 30 ms -> MEASURE ends at 400 cm (23200 µs); dist=400, timeout=1; the late echo fall is ignored.
- Echo_second toggles while sensor 0 is selected -> dist_1 is unchanged, and trigger order is 0,1,0,1 over 4 cycles.
- rst=0 pulse mid-MEASURE -> trig=0 and dist=0 immediately; the first trigger after release is on sensor 0.
- SONAR_FILTER_EN defined, results 100 then 200 cm -> reported 100, then 150.
